// File: rtl/famiclone_detect.sv
// famiclone_detect: power-on classic vs new-Dendy famiclone detector driving CIRAM /CE and /A13 grounding
module famiclone_detect #(
    parameter int INIT_CYCLES     = 15,
    parameter int LOW_SAMPLES     = 3,
    parameter int HIGH_SAMPLES    = 3,
    parameter int MISMATCH_THRESH = 1,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_rd_in,
    input  logic       ppu_a13,
    input  logic       ppu_not_a13,
    input  logic [1:0] mode,
    output logic       ground_en,
    output logic       new_dendy,
    output logic       detect_done,
    output logic       detect_timeout
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int LW = $clog2(LOW_SAMPLES + 1);
    localparam int HW = $clog2(HIGH_SAMPLES + 1);
    localparam int MW = $clog2(MISMATCH_THRESH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [LW-1:0] LO_MAX    = LW'(LOW_SAMPLES);
    localparam logic [HW-1:0] HI_MAX    = HW'(HIGH_SAMPLES);
    localparam logic [MW-1:0] MM_MAX    = MW'(MISMATCH_THRESH);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_INIT, S_OBSERVE, S_DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_rd_sync, r_a13_sync, r_na13_sync;
    logic [IW-1:0] r_init_cnt;
    logic [LW-1:0] r_lo_cnt;
    logic [HW-1:0] r_hi_cnt;
    logic [MW-1:0] r_mm_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_valid, w_lo_inc, w_hi_inc, w_mm_inc, w_quota, w_verdict;
    logic [LW-1:0] w_lo_next;
    logic [HW-1:0] w_hi_next;
    logic [MW-1:0] w_mm_next;

    // two-flop synchronizers, preset high so the bus looks idle (no read) out of reset
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_rd_sync   <= 2'b11;
            r_a13_sync  <= 2'b11;
            r_na13_sync <= 2'b11;
        end else begin
            r_rd_sync   <= {r_rd_sync[0], ppu_rd_in};
            r_a13_sync  <= {r_a13_sync[0], ppu_a13};
            r_na13_sync <= {r_na13_sync[0], ppu_not_a13};
        end
    end

    // sample qualification; only samples that fill a quota slot may count as mismatches
    always_comb begin
        w_valid   = (r_state == S_OBSERVE) && !r_rd_sync[1];
        w_lo_inc  = w_valid && !r_a13_sync[1] && (r_lo_cnt < LO_MAX);
        w_hi_inc  = w_valid && r_a13_sync[1] && (r_hi_cnt < HI_MAX);
        w_mm_inc  = (w_lo_inc || w_hi_inc) && (r_a13_sync[1] == r_na13_sync[1]) && (r_mm_cnt < MM_MAX);
        w_lo_next = r_lo_cnt + LW'(w_lo_inc);
        w_hi_next = r_hi_cnt + HW'(w_hi_inc);
        w_mm_next = r_mm_cnt + MW'(w_mm_inc);
        w_quota   = (w_lo_next == LO_MAX) && (w_hi_next == HI_MAX);
        w_verdict = (w_mm_next == MM_MAX);
    end

    // detection FSM with registered outputs; DONE is terminal until reset
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_init_cnt     <= '0;
            r_lo_cnt       <= '0;
            r_hi_cnt       <= '0;
            r_mm_cnt       <= '0;
            r_to_cnt       <= '0;
            ground_en      <= 1'b1;
            new_dendy      <= 1'b0;
            detect_done    <= 1'b0;
            detect_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + IW'(1);
                    if (r_init_cnt == INIT_LAST) begin
                        ground_en <= 1'b0;
                        if (mode == 2'b01 || mode == 2'b10) begin
                            r_state     <= S_DONE;
                            new_dendy   <= mode[1];
                            detect_done <= 1'b1;
                        end else begin
                            r_state <= S_OBSERVE;
                        end
                    end
                end
                S_OBSERVE: begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                    r_lo_cnt <= w_lo_next;
                    r_hi_cnt <= w_hi_next;
                    r_mm_cnt <= w_mm_next;
                    if (w_quota || r_to_cnt == TO_LAST) begin
                        r_state        <= S_DONE;
                        detect_done    <= 1'b1;
                        new_dendy      <= w_verdict;
                        detect_timeout <= !w_quota;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_famiclone_detect.sv
// tb_famiclone_detect: randomized check of famiclone_detect against a sample-list reference model
module tb_famiclone_detect;
    localparam int IC  = 15;
    localparam int LS  = 3;
    localparam int HS  = 3;
    localparam int TO  = 100;
    localparam int N   = IC + TO + 8;
    localparam int MT0 = 1;
    localparam int MT1 = 3;

    logic       m2 = 1'b0;
    logic       reset = 1'b1;
    logic       ppu_rd_in = 1'b1;
    logic       ppu_a13 = 1'b0;
    logic       ppu_not_a13 = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [1:0] ge, nd, dd, tmo;
    logic [2:0] stim [0:N+1];
    int         checks = 0;
    int         errors = 0;

    always #5 m2 = ~m2;

    famiclone_detect #(.INIT_CYCLES(IC), .LOW_SAMPLES(LS), .HIGH_SAMPLES(HS),
                       .MISMATCH_THRESH(MT0), .TIMEOUT_CYCLES(TO)) u0 (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
        .ppu_not_a13(ppu_not_a13), .mode(mode), .ground_en(ge[0]),
        .new_dendy(nd[0]), .detect_done(dd[0]), .detect_timeout(tmo[0]));

    famiclone_detect #(.INIT_CYCLES(IC), .LOW_SAMPLES(LS), .HIGH_SAMPLES(HS),
                       .MISMATCH_THRESH(MT1), .TIMEOUT_CYCLES(TO)) u1 (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
        .ppu_not_a13(ppu_not_a13), .mode(mode), .ground_en(ge[1]),
        .new_dendy(nd[1]), .detect_done(dd[1]), .detect_timeout(tmo[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // stim[k] = {rd, a13, not_a13} held during the interval before rising edge k
    task automatic gen(input int kind);
        int   i, len;
        logic a, rd;
        i = 0;
        while (i <= N + 1) begin
            len = $urandom_range(1, 4);
            a   = (kind == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            rd  = (kind == 4) ? 1'b1 : ($urandom_range(0, 3) == 0);
            for (int j = 0; j < len && i <= N + 1; j++) begin
                stim[i] = {rd, a, (kind == 0) ? ~a : (kind == 1) ? a : 1'($urandom_range(0, 1))};
                i++;
            end
        end
    endtask

    // the decision edge sees the inputs two edges earlier through the synchronizers
    function automatic void predict(input int mt, input logic [1:0] md,
                                    output int de, output int ndv, output int tt);
        int         lo, hi, mm;
        logic [2:0] s;
        lo  = 0;
        hi  = 0;
        mm  = 0;
        de  = IC;
        ndv = (md == 2'b10) ? 1 : 0;
        tt  = 0;
        if (md == 2'b01 || md == 2'b10) return;
        for (int e = IC + 1; e <= IC + TO; e++) begin
            s = stim[e - 2];
            if (!s[2]) begin
                if (!s[1] && lo < LS) begin
                    lo++;
                    if (s[1] == s[0]) mm++;
                end else if (s[1] && hi < HS) begin
                    hi++;
                    if (s[1] == s[0]) mm++;
                end
            end
            if ((lo == LS && hi == HS) || e == IC + TO) begin
                de  = e;
                ndv = (mm >= mt) ? 1 : 0;
                tt  = (lo == LS && hi == HS) ? 0 : 1;
                return;
            end
        end
    endfunction

    task automatic run(input int kind, input logic [1:0] md, input int abort_at);
        int de [2];
        int nv [2];
        int tt [2];
        gen(kind);
        mode  = md;
        reset = 1'b1;
        @(negedge m2);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ge%0d", k), 32'(ge[k]), 1);
            chk($sformatf("rst_dd%0d", k), 32'(dd[k]), 0);
            chk($sformatf("rst_nd%0d", k), 32'(nd[k]), 0);
            chk($sformatf("rst_to%0d", k), 32'(tmo[k]), 0);
        end
        predict(MT0, md, de[0], nv[0], tt[0]);
        predict(MT1, md, de[1], nv[1], tt[1]);
        reset = 1'b0;
        {ppu_rd_in, ppu_a13, ppu_not_a13} = stim[1];
        for (int e = 1; e <= N; e++) begin
            @(posedge m2);
            #1;
            {ppu_rd_in, ppu_a13, ppu_not_a13} = stim[e + 1];
            @(negedge m2);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ge%0d@%0d", k, e), 32'(ge[k]), (e < IC) ? 1 : 0);
                chk($sformatf("dd%0d@%0d", k, e), 32'(dd[k]), (e >= de[k]) ? 1 : 0);
                chk($sformatf("nd%0d@%0d", k, e), 32'(nd[k]), (e >= de[k]) ? nv[k] : 0);
                chk($sformatf("to%0d@%0d", k, e), 32'(tmo[k]), (e >= de[k]) ? tt[k] : 0);
            end
            if (e == abort_at) begin
                reset = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("abort_ge%0d", k), 32'(ge[k]), 1);
                    chk($sformatf("abort_dd%0d", k), 32'(dd[k]), 0);
                end
                return;
            end
        end
    endtask

    initial begin
        run(4, 2'b00, 0);
        run(0, 2'b00, 0);
        run(1, 2'b00, 0);
        run(3, 2'b00, 0);
        run(0, 2'b10, 0);
        run(1, 2'b01, 0);
        run(2, 2'b11, 0);
        run(3, 2'b00, IC + 14);
        run(0, 2'b00, 0);
        for (int r = 0; r < 8; r++) run(2, 2'($urandom_range(0, 3)), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/famiclone_detect.md
Name: famiclone_detect

Overview:
- Power-on console-type detector for the multicart top. It grounds the CIRAM /CE and PPU /A13 pins for a parametrised number of M2 cycles. It then samples PPU read cycles to decide whether the host is a "new Dendy" famiclone (PPU A13 and /A13 not complementary) or a classic console.
- It replaces the fixed 4-cycle init, the 2-read A13 sampling and the single-mismatch decision with parametrised counts, a mismatch threshold, a timeout and a mode override.
- Its outputs drive the top-level CIRAM /CE and /A13 tri-state selection.

Parameters:
- INIT_CYCLES, 15, M2 cycles spent in INIT with pins grounded (≥1).
- LOW_SAMPLES, 3, sampled reads with A13=0 required before deciding (≥1).
- HIGH_SAMPLES, 3, sampled reads with A13=1 required before deciding (≥1).
- MISMATCH_THRESH, 1, mismatching samples needed to declare new Dendy (≥1).
- TIMEOUT_CYCLES, 65535, M2 cycles allowed in OBSERVE before giving up (≥1).

Ports:
- m2, input, 1, CPU M2; the only clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- ppu_rd_in, input, 1, PPU /RD, asynchronous to m2.
- ppu_a13, input, 1, PPU A13, asynchronous.
- ppu_not_a13, input, 1, PPU /A13 pin level, asynchronous.
- mode, input, 2, 00/11 auto, 01 force classic, 10 force new Dendy; treated as static.
- ground_en, output, 1, 1 = top grounds CIRAM /CE and /A13.
- new_dendy, output, 1, detection/override result.
- detect_done, output, 1, decision final.
- detect_timeout, output, 1, OBSERVE expired before the sample quota was met.

Behaviour:
- Reset (async assert, deasserts synchronously to m2): state=INIT, all counters 0, all synchronizer flops 1. Outputs: ground_en=1, new_dendy=0, detect_done=0, detect_timeout=0.
- Synchronizers: ppu_rd_in, ppu_a13 and ppu_not_a13 each pass through 2 m2 flops (rd_s, a13_s, na13_s).
  - A sample is valid on a cycle when rd_s=0 and state=OBSERVE. This is level sampling; PPU reads that alias between m2 edges are acceptable.
- INIT:
  - init_cnt increments every cycle.
  - When init_cnt==INIT_CYCLES-1, go to OBSERVE next cycle. ground_en falls on that same edge, so ground_en is 1 for exactly INIT_CYCLES cycles after reset release.
  - ppu inputs are ignored in INIT, and the synchronizers keep running.
- OBSERVE:
  - to_cnt increments every cycle.
  - On a valid sample:
    - If a13_s=0 and lo_cnt<LOW_SAMPLES, increment lo_cnt.
    - If a13_s=1 and hi_cnt<HIGH_SAMPLES, increment hi_cnt.
    - A sample counts toward mismatch only if it also incremented lo_cnt or hi_cnt. It is a mismatch if a13_s==na13_s; then mm_cnt increments, saturating at MISMATCH_THRESH.
  - Quota met: lo_cnt==LOW_SAMPLES and hi_cnt==HIGH_SAMPLES, including a same-cycle final increment. Go to DONE next cycle with new_dendy=(mm_cnt≥MISMATCH_THRESH), counting that cycle's sample.
  - Timeout: to_cnt==TIMEOUT_CYCLES-1 with the quota not met. Go to DONE with detect_timeout=1 and new_dendy=(mm_cnt≥MISMATCH_THRESH) on the partial data.
  - If quota and timeout occur in the same cycle, quota wins and detect_timeout=0.
- DONE:
  - Terminal until reset.
  - detect_done=1.
  - new_dendy and detect_timeout hold.
  - Counters freeze.
- Mode override:
  - mode=01 forces new_dendy=0; mode=10 forces new_dendy=1.
  - Either override still runs INIT, skips OBSERVE, and enters DONE directly after INIT with detect_timeout=0.
  - Mode is sampled at the INIT→next transition only.
- new_dendy is 0 in INIT and OBSERVE and updates only on entry to DONE.
- Counter widths: $clog2(param+1). No wrap; every counter saturates or stops.
- Reset asserted mid-OBSERVE or in DONE: immediate return to reset values, including ground_en=1 asynchronously.

Test Plan:
1. Reset, mode=00, INIT_CYCLES=15, then hold everything idle -> ground_en=1 for exactly 15 rising m2 edges after reset release, then 0; detect_done stays 0.
2. Classic console: after INIT, alternate reads with A13=0/not_a13=1 and A13=1/not_a13=0 (rd low across ≥3 m2 edges each) -> detect_done=1 after 3 low and 3 high samples, new_dendy=0, detect_timeout=0.
3. New Dendy: same read pattern but not_a13 tied to A13 -> new_dendy=1 on entry to DONE. With MISMATCH_THRESH=4 and only 2 mismatching samples -> new_dendy=0.
4. TIMEOUT_CYCLES=100, only A13=0 reads (hi quota never met) -> detect_done=1 and detect_timeout=1 at cycle INIT_CYCLES+100; new_dendy follows partial mm_cnt.
5. mode=10 with classic stimulus -> new_dendy=1 and detect_done=1 one cycle after INIT ends, with no sampling. mode=01 with mismatching stimulus -> new_dendy=0.
6. Assert reset while in OBSERVE with lo_cnt=2 -> ground_en=1 immediately, detect_done=0; after release the full INIT length repeats and the counters restart from 0.
